// File: rtl/stack_unit.sv
// LIFO operand stack for the stack-machine datapath: push/pop/tos strobes, registered dout.
// Define STACK_ERR_EN to add the err_clr input and the sticky overflow/underflow outputs.
module stack_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              tos,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
`ifdef STACK_ERR_EN
    ,
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  sp;
    logic [CNT_W-1:0]  sp_nxt;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     wr_idx;
    logic              wr_en;
    logic              rd_en;
    logic              is_empty;
    logic              is_full;

    assign is_empty = (sp == '0);
    assign is_full  = (sp == DEPTH_C);
    assign top_idx  = AW'(sp - ONE_C);

    assign count = sp;
    assign empty = is_empty;
    assign full  = is_full;

    // Illegal operations fall through with no write and sp held, so stored entries stay intact.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = sp[AW-1:0];
        rd_en  = 1'b0;
        sp_nxt = sp;
        if (push && pop) begin
            if (is_empty) begin
                wr_en  = 1'b1;
                sp_nxt = sp + ONE_C;
            end else begin
                wr_en  = 1'b1;
                wr_idx = top_idx;
                rd_en  = 1'b1;
            end
        end else if (push) begin
            if (!is_full) begin
                wr_en  = 1'b1;
                sp_nxt = sp + ONE_C;
            end
        end else if (pop) begin
            if (!is_empty) begin
                rd_en  = 1'b1;
                sp_nxt = sp - ONE_C;
            end
        end else if (tos) begin
            if (!is_empty) begin
                rd_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp   <= '0;
            dout <= '0;
        end else begin
            sp <= sp_nxt;
            if (rd_en) begin
                dout <= mem[top_idx];
            end
        end
    end

    // Storage is not reset; the nonblocking write lets replace-top return the old value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= din;
        end
    end

`ifdef STACK_ERR_EN
    logic ovf_evt;
    logic unf_evt;

    assign ovf_evt = push && !pop && is_full;
    assign unf_evt = is_empty && (pop || (tos && !push));

    // A fault in the same cycle as err_clr takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_evt || (overflow && !err_clr);
            underflow <= unf_evt || (underflow && !err_clr);
        end
    end
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: stimulus queues expected state, a monitor compares after each edge.
// Flag checks are compiled in when STACK_ERR_EN is defined.
module tb_stack_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       push, pop, tos;
    logic [7:0] din;
    logic [7:0] dout;
    logic [3:0] count;
    logic       empty, full;
`ifdef STACK_ERR_EN
    logic       err_clr;
    logic       overflow, underflow;
`endif

    typedef struct {
        int         id;
        logic [7:0] dout;
        logic [3:0] count;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    always #5 clk = ~clk;

    stack_unit #(.DATA_W(8), .DEPTH(8), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .tos      (tos),
        .din      (din),
        .dout     (dout),
        .count    (count),
        .empty    (empty),
        .full     (full)
`ifdef STACK_ERR_EN
        ,
        .err_clr  (err_clr),
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    task automatic chk(input string nm, input int id, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step%0d got %h expected %h", nm, id, got, exp);
        end
    endtask

    // Drive one cycle of strobes and queue the state expected after the following edge.
    task automatic step(input logic p, input logic po, input logic t, input logic ec,
                        input logic [7:0] d, input logic [7:0] ed, input logic [3:0] ecnt,
                        input logic eo, input logic eu);
        exp_t e;
        @(negedge clk);
        push = p; pop = po; tos = t; din = d;
`ifdef STACK_ERR_EN
        err_clr = ec;
`endif
        e.id = step_id; e.dout = ed; e.count = ecnt; e.ovf = eo; e.unf = eu;
        step_id++;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("dout",  e.id, dout, e.dout);
                chk("count", e.id, {4'h0, count}, {4'h0, e.count});
                chk("empty", e.id, {7'h0, empty}, {7'h0, (e.count == 4'd0)});
                chk("full",  e.id, {7'h0, full},  {7'h0, (e.count == 4'd8)});
`ifdef STACK_ERR_EN
                chk("overflow",  e.id, {7'h0, overflow},  {7'h0, e.ovf});
                chk("underflow", e.id, {7'h0, underflow}, {7'h0, e.unf});
`endif
            end
        end
    end

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", q.size());
        end
    endtask

    initial begin : stim
        rst = 1'b1; push = 0; pop = 0; tos = 0; din = 8'h00;
`ifdef STACK_ERR_EN
        err_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", -1, {4'h0, count}, 8'h00);
        chk("rst_dout",  -1, dout, 8'h00);
        chk("rst_empty", -1, {7'h0, empty}, 8'h01);
        chk("rst_full",  -1, {7'h0, full}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        //    push pop tos clr din    dout   cnt ovf unf
        step(1, 0, 0, 0, 8'h11, 8'h00, 1, 0, 0);
        step(1, 0, 0, 0, 8'h22, 8'h00, 2, 0, 0);
        step(1, 0, 0, 0, 8'h33, 8'h00, 3, 0, 0);
        step(0, 0, 1, 0, 8'h00, 8'h33, 3, 0, 0);
        step(0, 1, 0, 0, 8'h00, 8'h33, 2, 0, 0);
        step(0, 1, 0, 0, 8'h00, 8'h22, 1, 0, 0);
        step(0, 1, 0, 0, 8'h00, 8'h11, 0, 0, 0);

        for (int i = 1; i <= 8; i++)
            step(1, 0, 0, 0, 8'(i), 8'h11, 4'(i), 0, 0);
        step(1, 1, 0, 0, 8'hEE, 8'h08, 8, 0, 0);
        step(1, 0, 0, 0, 8'hFF, 8'h08, 8, 1, 0);
        step(0, 1, 0, 0, 8'h00, 8'hEE, 7, 1, 0);
        for (int i = 7; i >= 1; i--)
            step(0, 1, 0, 0, 8'h00, 8'(i), 4'(i - 1), 1, 0);

        step(0, 1, 0, 0, 8'h00, 8'h01, 0, 1, 1);
        step(0, 0, 1, 0, 8'h00, 8'h01, 0, 1, 1);
        step(0, 0, 0, 1, 8'h00, 8'h01, 0, 0, 0);
        step(0, 1, 0, 1, 8'h00, 8'h01, 0, 0, 1);
        step(0, 0, 0, 1, 8'h00, 8'h01, 0, 0, 0);

        step(1, 0, 0, 0, 8'hA5, 8'h01, 1, 0, 0);
        step(1, 1, 0, 0, 8'h5A, 8'hA5, 1, 0, 0);
        step(0, 0, 1, 0, 8'h00, 8'h5A, 1, 0, 0);
        step(0, 1, 0, 0, 8'h00, 8'h5A, 0, 0, 0);

        step(1, 1, 0, 0, 8'h77, 8'h5A, 1, 0, 1);
        step(0, 0, 1, 0, 8'h00, 8'h77, 1, 0, 1);
        step(0, 1, 0, 0, 8'h00, 8'h77, 0, 0, 1);
        step(0, 0, 0, 1, 8'h00, 8'h77, 0, 0, 0);

        step(1, 0, 1, 0, 8'h99, 8'h77, 1, 0, 0);
        step(0, 0, 1, 0, 8'h00, 8'h99, 1, 0, 0);
        step(0, 0, 0, 0, 8'h00, 8'h99, 1, 0, 0);
        step(1, 0, 0, 0, 8'h12, 8'h99, 2, 0, 0);
        step(1, 0, 0, 0, 8'h34, 8'h99, 3, 0, 0);

        drain();
        @(negedge clk);
        push = 0; pop = 0; tos = 0;
`ifdef STACK_ERR_EN
        err_clr = 1'b0;
`endif
        #2 rst = 1'b1;
        #1;
        chk("arst_count", -2, {4'h0, count}, 8'h00);
        chk("arst_dout",  -2, dout, 8'h00);
        chk("arst_empty", -2, {7'h0, empty}, 8'h01);
        #1 rst = 1'b0;

        step(1, 0, 0, 0, 8'hC3, 8'h00, 1, 0, 0);
        step(0, 0, 1, 0, 8'h00, 8'hC3, 1, 0, 0);
        step(0, 1, 0, 0, 8'h00, 8'hC3, 0, 0, 0);
        step(0, 0, 0, 0, 8'h00, 8'hC3, 0, 0, 0);

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
Hardware LIFO operand stack for the multicycle stack-machine datapath. It is driven by the controller's push/pop/tos strobes and supplies the top-of-stack operand to the ALU/A register path. It accepts write data from the datapath's DataSelect mux (memory data or ALU result). It also exports occupancy and fault status for the controller and the bench.

Parameters:
DATA_W, 8, operand width in bits (matches 8-bit instruction/data word)
DEPTH, 8, number of stack entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of occupancy count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
push  input  1  write din onto stack this cycle
pop  input  1  remove top entry; value goes to dout
tos  input  1  copy top entry to dout without removing it
din  input  DATA_W  data to push
dout  output  DATA_W  registered read data (last pop/tos result)
count  output  CNT_W  current number of valid entries
empty  output  1  count == 0 (combinational from count)
full  output  1  count == DEPTH (combinational from count)
err_clr  input  1  clears sticky fault flags (present only with STACK_ERR_EN)
overflow  output  1  sticky: push attempted while full (STACK_ERR_EN only)
underflow  output  1  sticky: pop/tos attempted while empty (STACK_ERR_EN only)

Behaviour:
- One clock; reset is asynchronous and active-high. On rst: sp/count=0, dout=0, overflow=0, underflow=0; storage contents are don't-care (not reset).
- Storage: DEPTH x DATA_W register array; sp points to the next free slot; top = mem[sp-1].
- All updates on the rising clk edge; dout valid the cycle after the strobe (latency 1).
- push only, not full: mem[sp]<=din, sp<=sp+1; dout unchanged.
- push only, full: ignored (no write, sp held); overflow set.
- pop only, not empty: dout<=mem[sp-1], sp<=sp-1.
- pop only, empty: sp held, dout held; underflow set.
- tos only, not empty: dout<=mem[sp-1], sp unchanged. tos while empty: dout held; underflow set.
- push+pop same cycle, not empty: replace top. dout<=old mem[sp-1], mem[sp-1]<=din, sp unchanged. Legal when full.
- push+pop same cycle, empty: treated as push only; underflow set.
- tos with push or pop: tos is ignored; push/pop rules apply.
- No strobes: all state held.
- No wrap-around: sp saturates in [0, DEPTH]; an illegal op never corrupts stored entries.
- rst asserted mid-operation: state is cleared immediately regardless of the strobes in flight.
- Sticky flags stay set until err_clr or rst. If err_clr and a new fault occur in the same cycle, the new fault wins (flag reads 1).

Optional Feature:
STACK_ERR_EN -- when defined: err_clr, overflow and underflow ports exist and behave as described. When undefined: those ports are omitted, illegal push/pop/tos are still silently ignored with state held, and the remaining behaviour is identical.

Test Plan:
- Reset, then push 8'h11, 8'h22, 8'h33 on consecutive cycles -> count=3; tos -> dout=8'h33 next cycle; count stays 3.
- Pop three times -> dout=8'h33, 8'h22, 8'h11 on successive cycles; count 2,1,0; empty=1 after last pop.
- Fill with DEPTH pushes (full=1), then push 8'hFF -> count=DEPTH, overflow=1, top unchanged; pop -> dout = last legal value.
- From empty: pop, then tos -> dout held at prior value, underflow=1, count=0; pulse err_clr -> underflow=0.
- Push 8'hA5, then push+pop with din=8'h5A -> dout=8'hA5, count=1; subsequent tos -> dout=8'h5A.
- Push 2 entries, assert rst asynchronously between edges -> count=0, dout=0, empty=1 immediately; push after release works from slot 0.
